// File: rtl/lbm_pkg.sv
// Shared LBM streaming-stage definitions: lattice geometry, D2Q9 direction table, sequencer states.
package lbm_pkg;

  localparam int unsigned GRID_W        = 16;
  localparam int unsigned GRID_H        = 16;
  localparam int unsigned Q             = 9;
  localparam int unsigned DATA_WIDTH    = 16;
  localparam int unsigned ADDRESS_WIDTH = $clog2(GRID_W * GRID_H) + 1;
  localparam int unsigned NODE_AW       = ADDRESS_WIDTH - 1;
  localparam int unsigned X_W           = $clog2(GRID_W);
  localparam int unsigned Y_W           = $clog2(GRID_H);

  typedef logic [3:0] dir_t;

  // D2Q9 opposite directions: 0<->0, 1<->3, 2<->4, 5<->7, 6<->8
  localparam dir_t OPPOSITE [Q] = '{4'd0, 4'd3, 4'd4, 4'd1, 4'd2, 4'd7, 4'd8, 4'd5, 4'd6};

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IN,
    ISSUE,
    ADVANCE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/stream_write_sequencer_if.sv
// Node/collision/memory bus between the streaming sequencer and its neighbours.
interface stream_write_sequencer_if;
  import lbm_pkg::*;

  logic [ADDRESS_WIDTH-1:0]   node_x;
  logic [ADDRESS_WIDTH-1:0]   node_y;
  logic [Q*ADDRESS_WIDTH-1:0] addr_in;
  logic                       in_valid;
  logic                       in_ready;
  logic [Q*DATA_WIDTH-1:0]    in_f;
  logic                       mem_we;
  dir_t                       mem_dir;
  logic [NODE_AW-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic                       mem_ack;

  modport master (
    output node_x, node_y, in_ready, mem_we, mem_dir, mem_addr, mem_wdata,
    input  addr_in, in_valid, in_f, mem_ack
  );

  modport slave (
    input  node_x, node_y, in_ready, mem_we, mem_dir, mem_addr, mem_wdata,
    output addr_in, in_valid, in_f, mem_ack
  );

endinterface

// File: rtl/lattice_node_counter.sv
// Raster-order (x fastest) lattice node counter with clear, advance and last-node flag.
module lattice_node_counter
  import lbm_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last_node_c
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  // Next raster position: wrap x at the row end and step y
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (x_q == X_W'(GRID_W - 1)) begin
        x_d = '0;
        y_d = (y_q == Y_W'(GRID_H - 1)) ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  // Position registers
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign last_node_c = (x_q == X_W'(GRID_W - 1)) && (y_q == Y_W'(GRID_H - 1));

endmodule

// File: rtl/stream_write_sequencer.sv
// Frame-level LBM streaming controller: walks nodes in raster order, accepts each node's
// post-collision distributions and serialises the streamed writes onto one memory port.
// Build option BOUNCE_BACK_EN: off-grid directions become writes to the current node in
// the opposite plane instead of being dropped.
module stream_write_sequencer
  import lbm_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  stream_write_sequencer_if.master bus
);

  seq_state_t                 state_q, state_d;
  dir_t                       dir_q, dir_d;
  logic [Q*ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [Q*DATA_WIDTH-1:0]    f_q, f_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       in_ready_q, in_ready_d;
  logic                       mem_we_q, mem_we_d;
  dir_t                       mem_dir_q, mem_dir_d;
  logic [NODE_AW-1:0]         mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]      mem_wdata_q, mem_wdata_d;

  logic                       cnt_clear;
  logic                       cnt_advance;
  logic                       last_node_c;
  logic [X_W-1:0]             x;
  logic [Y_W-1:0]             y;
  logic [ADDRESS_WIDTH-1:0]   addr_sl [Q];
  logic [DATA_WIDTH-1:0]      f_sl [Q];
  logic [ADDRESS_WIDTH-1:0]   tgt;
  logic                       tgt_off;
  logic                       step;
`ifdef BOUNCE_BACK_EN
  logic [NODE_AW-1:0]         node_addr;
`endif

  lattice_node_counter u_node_counter (
    .clk         (clk),
    .reset       (reset),
    .clear       (cnt_clear),
    .advance     (cnt_advance),
    .x           (x),
    .y           (y),
    .last_node_c (last_node_c)
  );

`ifdef BOUNCE_BACK_EN
  assign node_addr = NODE_AW'(32'(y) * GRID_W + 32'(x));
`endif

  // Per-direction slots of the live payload while accepting, of the latched payload otherwise
  always_comb begin
    for (int unsigned d = 0; d < Q; d++) begin
      if (state_q == WAIT_IN) begin
        addr_sl[d] = bus.addr_in[(Q-d)*ADDRESS_WIDTH-1 -: ADDRESS_WIDTH];
        f_sl[d]    = bus.in_f[(Q-d)*DATA_WIDTH-1 -: DATA_WIDTH];
      end else begin
        addr_sl[d] = addr_q[(Q-d)*ADDRESS_WIDTH-1 -: ADDRESS_WIDTH];
        f_sl[d]    = f_q[(Q-d)*DATA_WIDTH-1 -: DATA_WIDTH];
      end
    end
  end

  // Next state plus the registered view of the outputs for that state
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    addr_d      = addr_q;
    f_d         = f_q;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    step        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clear = 1'b1;
          state_d   = WAIT_IN;
        end
      end
      WAIT_IN: begin
        if (bus.in_valid) begin
          addr_d  = bus.addr_in;
          f_d     = bus.in_f;
          dir_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A pending write waits for its ack; a skipped direction takes one cycle
        step = mem_we_q ? bus.mem_ack : 1'b1;
        if (step) begin
          if (dir_q == dir_t'(Q - 1)) state_d = ADVANCE;
          else                        dir_d   = dir_q + dir_t'(1);
        end
      end
      ADVANCE: begin
        cnt_advance = 1'b1;
        state_d     = last_node_c ? DONE : WAIT_IN;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    in_ready_d  = (state_d == WAIT_IN);
    tgt         = addr_sl[dir_d];
    tgt_off     = tgt[ADDRESS_WIDTH-1];
    mem_we_d    = 1'b0;
    mem_dir_d   = mem_dir_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (state_d == ISSUE) begin
`ifdef BOUNCE_BACK_EN
      mem_we_d    = 1'b1;
      mem_dir_d   = tgt_off ? OPPOSITE[dir_d] : dir_d;
      mem_addr_d  = tgt_off ? node_addr : tgt[NODE_AW-1:0];
      mem_wdata_d = f_sl[dir_d];
`else
      if (!tgt_off) begin
        mem_we_d    = 1'b1;
        mem_dir_d   = dir_d;
        mem_addr_d  = tgt[NODE_AW-1:0];
        mem_wdata_d = f_sl[dir_d];
      end
`endif
    end
  end

  // State, payload latches and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dir_q       <= '0;
      addr_q      <= '0;
      f_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_dir_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      addr_q      <= addr_d;
      f_q         <= f_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_dir_q   <= mem_dir_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_dir   = mem_dir_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.node_x    = ADDRESS_WIDTH'(x);
  assign bus.node_y    = ADDRESS_WIDTH'(y);

endmodule

// File: tb/tb_stream_write_sequencer.sv
// Bench for stream_write_sequencer: streaming-unit and memory models drive the DUT, a
// scoreboard of expected writes (built from lattice geometry) is checked every cycle.
module tb_stream_write_sequencer;

  localparam int GW        = 16;
  localparam int GH        = 16;
  localparam int NQ        = 9;
  localparam int AW        = 9;
  localparam int DW        = 16;
  localparam int NODES     = GW * GH;
  localparam int FRAME_CYC = 11 * NODES + 1;
`ifdef BOUNCE_BACK_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  typedef struct {
    int n;
    int dir;
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  stream_write_sequencer_if bus ();

  stream_write_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  int cx  [NQ] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  int cy  [NQ] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
  int opp [NQ] = '{0, 3, 4, 1, 2, 7, 8, 5, 6};

  int  checks = 0;
  int  errors = 0;
  int  mode   = 0;   // 0: always valid/ack, 1: input gaps and memory stalls
  wr_t exp_q [$];

  // Checker/model state
  int  model_n, cyc, wr_cnt, done_cnt, run, stall_runs;
  bit  counting, have_prev;
  int  pdir, paddr, pdata;
  int  corner_cnt, node0_idx, c4_dir, c4_addr;
  int  n85_cnt, n85_first, n85_last, lit_addr, lit_data;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int f_val(input int n, input int d);
    return (n * 16 + d) & 16'hFFFF;
  endfunction

  function automatic bit on_grid(input int tx, input int ty);
    return tx >= 0 && tx < GW && ty >= 0 && ty < GH;
  endfunction

  // Expected memory writes of node n, in direction order
  task automatic push_node(input int n);
    for (int d = 0; d < NQ; d++) begin
      int  tx;
      int  ty;
      wr_t w;
      tx     = n % GW + cx[d];
      ty     = n / GW + cy[d];
      w.n    = n;
      w.data = f_val(n, d);
      if (on_grid(tx, ty)) begin
        w.dir  = d;
        w.addr = ty * GW + tx;
        exp_q.push_back(w);
      end else if (BOUNCE) begin
        w.dir  = opp[d];
        w.addr = n;
        exp_q.push_back(w);
      end
    end
  endtask

  // Streaming-unit and memory environment, updated just after each rising edge
  initial begin
    int  hold;
    int  want;
    bit  prev_we;
    bit  prev_ack;
    bit  ack;
    hold = 0; want = 0; prev_we = 0; prev_ack = 0;
    bus.addr_in  = '0;
    bus.in_f     = '0;
    bus.in_valid = 1'b0;
    bus.mem_ack  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < NQ; d++) begin
        int x;
        int y;
        int tx;
        int ty;
        x  = int'(bus.node_x);
        y  = int'(bus.node_y);
        tx = x + cx[d];
        ty = y + cy[d];
        bus.addr_in[(NQ-d)*AW-1 -: AW] = on_grid(tx, ty) ? 9'(ty * GW + tx) : (9'h100 | 9'(d));
        bus.in_f[(NQ-d)*DW-1 -: DW]    = 16'(f_val(y * GW + x, d));
      end
      bus.in_valid = (mode == 1) ? ($urandom % 3 != 0) : 1'b1;
      if (bus.mem_we) begin
        if (prev_we && !prev_ack) hold++;
        else begin
          hold = 0;
          want = $urandom % 2;
        end
        if (mode == 0)               ack = 1'b1;
        else if (bus.mem_dir == 4'd2) ack = (hold >= 3);
        else                         ack = (hold >= want);
      end else begin
        ack = (mode == 0) ? 1'b1 : 1'($urandom % 2);
      end
      bus.mem_ack = ack;
      prev_we     = bus.mem_we;
      prev_ack    = ack;
    end
  end

  // Compare process: checks DUT outputs against the model on every falling edge
  initial begin
    wr_t w;
    model_n = 0; cyc = 0; wr_cnt = 0; done_cnt = 0; run = 0; stall_runs = 0;
    counting = 0; have_prev = 0; pdir = 0; paddr = 0; pdata = 0;
    corner_cnt = 0; node0_idx = 0; c4_dir = -1; c4_addr = -1;
    n85_cnt = 0; n85_first = 0; n85_last = 0; lit_addr = -1; lit_data = -1;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        model_n   = 0;
        counting  = 0;
        have_prev = 0;
        run       = 0;
      end else begin
        if (counting) cyc++;
        if (bus.in_ready) begin
          chk("node_x", int'(bus.node_x), model_n % GW);
          chk("node_y", int'(bus.node_y), model_n / GW);
          chk("busy_while_ready", int'(busy), 1);
          if (bus.in_valid) begin
            push_node(model_n);
            model_n++;
          end
        end
        if (have_prev) begin
          chk("hold_we", int'(bus.mem_we), 1);
          if (bus.mem_we) begin
            chk("hold_dir", int'(bus.mem_dir), pdir);
            chk("hold_addr", int'(bus.mem_addr), paddr);
            chk("hold_data", int'(bus.mem_wdata), pdata);
          end
        end
        if (bus.mem_we) begin
          run = have_prev ? run + 1 : 1;
          if (bus.mem_ack) begin
            have_prev = 0;
            if (exp_q.size() == 0) begin
              chk("unexpected_write", int'(bus.mem_addr), -1);
            end else begin
              w = exp_q.pop_front();
              chk("wr_dir", int'(bus.mem_dir), w.dir);
              chk("wr_addr", int'(bus.mem_addr), w.addr);
              chk("wr_data", int'(bus.mem_wdata), w.data);
              wr_cnt++;
              if (w.n == 0) begin
                corner_cnt++;
                node0_idx++;
                if (node0_idx == 4) begin
                  c4_dir  = int'(bus.mem_dir);
                  c4_addr = int'(bus.mem_addr);
                end
              end
              if (w.n == 85) begin
                if (n85_cnt == 0) n85_first = cyc;
                n85_last = cyc;
                n85_cnt++;
                if (w.dir == 2) begin
                  lit_addr = int'(bus.mem_addr);
                  lit_data = int'(bus.mem_wdata);
                end
              end
            end
            if (mode == 1 && bus.mem_dir == 4'd2) begin
              chk("stall_run", run, 4);
              stall_runs++;
            end
          end else begin
            have_prev = 1;
            pdir      = int'(bus.mem_dir);
            paddr     = int'(bus.mem_addr);
            pdata     = int'(bus.mem_wdata);
          end
        end
        if (done) begin
          done_cnt++;
          chk("busy_at_done", int'(busy), 1);
          if (mode == 0) chk("done_cycle", cyc, FRAME_CYC);
          chk("nodes_done", model_n, NODES);
          chk("queue_empty", exp_q.size(), 0);
          chk("frame_writes", wr_cnt, BOUNCE ? 2304 : 2116);
          counting = 0;
        end
        if (start && !busy) begin
          counting   = 1;
          cyc        = 0;
          model_n    = 0;
          wr_cnt     = 0;
          corner_cnt = 0;
          node0_idx  = 0;
          n85_cnt    = 0;
          stall_runs = 0;
          exp_q.delete();
        end
      end
    end
  end

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
    chk({tag, "_mem_we"}, int'(bus.mem_we), 0);
  endtask

  // Directed sequence
  initial begin
    bit found;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_idle("reset");
    chk("reset_node_x", int'(bus.node_x), 0);
    chk("reset_node_y", int'(bus.node_y), 0);
    chk("reset_mem_dir", int'(bus.mem_dir), 0);
    chk("reset_mem_addr", int'(bus.mem_addr), 0);
    chk("reset_mem_wdata", int'(bus.mem_wdata), 0);

    // Frame 1: free-running, with a start pulse mid-frame and one in the done cycle
    done_cnt = 0;
    pulse_start();
    chk("busy_after_start", int'(busy), 1);
    repeat (100) @(posedge clk);
    #1;
    pulse_start();
    wait_done(6000);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("post_done_busy", int'(busy), 0);
      chk("post_done_done", int'(done), 0);
      @(posedge clk);
      #1;
    end
    chk("frame1_done_pulses", done_cnt, 1);
    chk("corner_writes", corner_cnt, BOUNCE ? 9 : 4);
    chk("corner_4th_dir", c4_dir, BOUNCE ? 1 : 5);
    chk("corner_4th_addr", c4_addr, BOUNCE ? 0 : 17);
    chk("n85_writes", n85_cnt, 9);
    chk("n85_span", n85_last - n85_first, 8);
    chk("n85_dir2_addr", lit_addr, 101);
    chk("n85_dir2_data", lit_data, 1362);

    // Frame 2: input gaps and memory stalls (3-cycle stall on every plane-2 write)
    done_cnt = 0;
    mode     = 1;
    pulse_start();
    wait_done(30000);
    repeat (3) @(posedge clk);
    #1;
    mode = 0;
    chk("frame2_done_pulses", done_cnt, 1);
    chk("stall_runs", stall_runs, BOUNCE ? 256 : 240);
    repeat (3) @(posedge clk);
    #1;

    // Frame 3: reset while issuing node 37 (5,2) direction 4, then restart
    pulse_start();
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus.mem_we && bus.mem_dir == 4'd4 && bus.node_x == 9'd5 && bus.node_y == 9'd2) found = 1;
    end
    chk("reach_node37_dir4", int'(found), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle("abort");
    chk("abort_node_x", int'(bus.node_x), 0);
    chk("abort_mem_addr", int'(bus.mem_addr), 0);
    done_cnt = 0;
    pulse_start();
    chk("restart_in_ready", int'(bus.in_ready), 1);
    chk("restart_node_x", int'(bus.node_x), 0);
    chk("restart_node_y", int'(bus.node_y), 0);
    wait_done(6000);
    repeat (3) @(posedge clk);
    #1;
    chk("frame3_done_pulses", done_cnt, 1);
    check_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
